controlador_rafaga_ram: RTL and testbench
=========================================

Name: controlador_rafaga_ram

Overview:
- Burst initiator that drives the 16x32 register-file RAM port: write enable, 32-bit data in, 4-bit address, 32-bit combinational data out.
- Accepts one burst request at a time over a valid/ready handshake.
- Write bursts consume words from an input stream into consecutive RAM addresses; read bursts stream RAM words out.
- Sits between the datapath/test sequencer and the RAM, so no other block toggles the RAM write enable directly.

Parameters:
- ANCHO_DATOS, 32, data word width; must match the RAM.
- ANCHO_DIR, 4, address width; RAM depth is 2**ANCHO_DIR = 16.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  burst request present.
- req_ready  output  1  controller can accept a request.
- req_escritura  input  1  1 = write burst, 0 = read burst.
- req_dir  input  ANCHO_DIR  start address.
- req_longitud  input  ANCHO_DIR+1  beat count, 0..16.
- wdat_valid  input  1  write word present.
- wdat_ready  output  1  write word accepted this cycle.
- wdat  input  ANCHO_DATOS  write word.
- rdat_valid  output  1  read word present.
- rdat_ready  input  1  consumer takes read word.
- rdat  output  ANCHO_DATOS  read word.
- hecho  output  1  one-cycle pulse when a burst completes.
- ram_we  output  1  to RAM habilitarEscritura.
- ram_din  output  ANCHO_DATOS  to RAM entradaDatos.
- ram_dir  output  ANCHO_DIR  to RAM direccion.
- ram_dout  input  ANCHO_DATOS  from RAM salidaDatos.

Behaviour:
- Reset (async, rst_n=0): state REPOSO; all outputs 0; internal address/count 0. Reset mid-burst aborts immediately: ram_we drops asynchronously, the burst is discarded, and no hecho is produced.
- All RAM-side outputs are registered, so no combinational glitches reach the level-sensitive RAM.
- States: REPOSO, ESCRIBE, LEE, FIN.
- REPOSO:
  - req_ready = 1 when rdat_valid == 0.
  - On req_valid & req_ready: latch start address into dir_act and ram_dir, latch length into cuenta, go to ESCRIBE or LEE per req_escritura.
  - req_longitud == 0: go straight to FIN, no RAM access.
  - req_longitud > 16: saturate to 16.
- ESCRIBE:
  - wdat_ready = !ram_we; at most one beat every 2 cycles.
  - On wdat_valid & wdat_ready: next cycle ram_we=1 for exactly one cycle, ram_din=wdat, ram_dir=dir_act.
  - Then dir_act = dir_act+1 mod 16 and cuenta-1.
  - When the beat that makes cuenta 0 has its ram_we cycle, go to FIN the following cycle.
  - ram_we is never 1 outside ESCRIBE.
- LEE:
  - ram_dir holds dir_act.
  - When rdat_valid==0 or rdat_ready==1: rdat <= ram_dout, rdat_valid <= 1, dir_act and ram_dir advance mod 16, cuenta-1.
  - Throughput is one word per cycle with rdat_ready held at 1; first rdat_valid arrives 1 cycle after entering LEE.
  - A rdat_ready=0 stall holds rdat, dir_act and cuenta.
  - After the last capture go to FIN; rdat_valid stays up until consumed.
- FIN: hecho=1 for one cycle, then REPOSO.
- Address wrap: 15 -> 0 silently; a 16-beat burst touches every word exactly once.
- wdat_valid outside ESCRIBE is ignored (wdat_ready=0). rdat_ready without rdat_valid has no effect.
- The new request handshake is blocked while rdat_valid is held, so read data is never overwritten.

Optional Feature:
- Macro SUMA_VERIFICACION_EN.
- Defined:
  - Adds output suma (ANCHO_DATOS) holding the XOR of every word written or read in the current burst.
  - Cleared to 0 on request accept; valid on the hecho cycle; held until the next accept; 0 at reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Write burst req_dir=3, len=4, words 0xA0..0xA3 -> ram_we pulses 4 times, each 1 cycle, addrs 3,4,5,6; then hecho pulse; RAM[3..6]=0xA0..0xA3.
- Read back same range with rdat_ready=1 -> rdat 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles; hecho 1 cycle after last capture.
- Wrap: write len=3 from addr 14 (0x11,0x22,0x33) -> addrs 14,15,0; read from 14 returns same order.
- Backpressure: read len=2 with rdat_ready=0 for 5 cycles -> rdat holds first word, rdat_valid=1, req_ready=0 throughout.
- Length 0 request -> no ram_we, hecho 1 cycle after accept. Length 20 -> exactly 16 beats.
- rst_n low during a write burst at beat 2 -> ram_we=0 immediately; state REPOSO, req_ready=1 after release; SUMA_VERIFICACION_EN build: suma=0xA0^0xA1^0xA2^0xA3 after the first scenario.

Source files
------------

// File: rtl/controlador_rafaga_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controlador_rafaga_ram: burst initiator for the 16x32 register-file RAM;   |
// | optional SUMA_VERIFICACION_EN adds a per-burst XOR checksum output.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module controlador_rafaga_ram #(
   parameter int ANCHO_DATOS = 32,
   parameter int ANCHO_DIR   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_escritura,
   input  logic [ANCHO_DIR-1:0]   req_dir,
   input  logic [ANCHO_DIR:0]     req_longitud,
   input  logic                   wdat_valid,
   output logic                   wdat_ready,
   input  logic [ANCHO_DATOS-1:0] wdat,
   output logic                   rdat_valid,
   input  logic                   rdat_ready,
   output logic [ANCHO_DATOS-1:0] rdat,
   output logic                   hecho,
   output logic                   ram_we,
   output logic [ANCHO_DATOS-1:0] ram_din,
   output logic [ANCHO_DIR-1:0]   ram_dir,
   input  logic [ANCHO_DATOS-1:0] ram_dout
`ifdef SUMA_VERIFICACION_EN
   ,
   output logic [ANCHO_DATOS-1:0] suma
`endif
);

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      ESCRIBE = 2'd1,
      LEE     = 2'd2,
      FIN     = 2'd3
   } estado_t;

   localparam logic [ANCHO_DIR:0] c_profundidad = {1'b1, {ANCHO_DIR{1'b0}}};
   localparam logic [ANCHO_DIR:0] c_uno         = {{ANCHO_DIR{1'b0}}, 1'b1};

   estado_t              r_estado;
   estado_t              w_estado_sig;
   logic [ANCHO_DIR-1:0] r_dir_act;
   logic [ANCHO_DIR:0]   r_cuenta;
   logic                 r_arrancado;
   logic                 w_acepta;
   logic                 w_beat;
   logic                 w_captura;
   logic [ANCHO_DIR:0]   w_long_sat;
   logic [ANCHO_DIR-1:0] w_dir_sig;

   assign w_long_sat = (req_longitud > c_profundidad) ? c_profundidad : req_longitud;
   assign w_dir_sig  = r_dir_act + 1'b1;

   // r_arrancado keeps req_ready low while reset is asserted and for the first clock after.
   assign req_ready  = (r_estado == REPOSO) & r_arrancado & ~rdat_valid;
   assign wdat_ready = (r_estado == ESCRIBE) & ~ram_we;
   assign w_acepta   = req_valid & req_ready;
   assign w_beat     = wdat_valid & wdat_ready;
   assign w_captura  = (r_estado == LEE) & (~rdat_valid | rdat_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= REPOSO;
      end else begin
         r_estado <= w_estado_sig;
      end
   end

   always_comb begin
      w_estado_sig = r_estado;
      hecho        = 1'b0;
      case (r_estado)
         REPOSO: begin
            if (w_acepta) begin
               if (w_long_sat == '0) begin
                  w_estado_sig = FIN;
               end else if (req_escritura) begin
                  w_estado_sig = ESCRIBE;
               end else begin
                  w_estado_sig = LEE;
               end
            end
         end
         ESCRIBE: begin
            // Leave only after the final beat's write-enable cycle has been issued.
            if (ram_we && (r_cuenta == '0)) begin
               w_estado_sig = FIN;
            end
         end
         LEE: begin
            if (w_captura && (r_cuenta == c_uno)) begin
               w_estado_sig = FIN;
            end
         end
         FIN: begin
            hecho        = 1'b1;
            w_estado_sig = REPOSO;
         end
         default: w_estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arrancado <= 1'b0;
         r_dir_act   <= '0;
         r_cuenta    <= '0;
         ram_we      <= 1'b0;
         ram_din     <= '0;
         ram_dir     <= '0;
         rdat        <= '0;
         rdat_valid  <= 1'b0;
`ifdef SUMA_VERIFICACION_EN
         suma        <= '0;
`endif
      end else begin
         r_arrancado <= 1'b1;
         ram_we      <= 1'b0;
         if (rdat_valid && rdat_ready) begin
            rdat_valid <= 1'b0;
         end
         if (w_acepta) begin
            r_dir_act <= req_dir;
            ram_dir   <= req_dir;
            r_cuenta  <= w_long_sat;
`ifdef SUMA_VERIFICACION_EN
            suma      <= '0;
`endif
         end
         if (w_beat) begin
            ram_we    <= 1'b1;
            ram_din   <= wdat;
            ram_dir   <= r_dir_act;
            r_dir_act <= w_dir_sig;
            r_cuenta  <= r_cuenta - 1'b1;
`ifdef SUMA_VERIFICACION_EN
            suma      <= suma ^ wdat;
`endif
         end
         // A capture in the same cycle as a consume overrides the clear above.
         if (w_captura) begin
            rdat       <= ram_dout;
            rdat_valid <= 1'b1;
            r_dir_act  <= w_dir_sig;
            ram_dir    <= w_dir_sig;
            r_cuenta   <= r_cuenta - 1'b1;
`ifdef SUMA_VERIFICACION_EN
            suma       <= suma ^ ram_dout;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controlador_rafaga_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_controlador_rafaga_ram: directed vector bench with a behavioural RAM.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_controlador_rafaga_ram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_escritura = 1'b0;
   logic [3:0]  req_dir = '0;
   logic [4:0]  req_longitud = '0;
   logic        wdat_valid = 1'b0;
   logic        wdat_ready;
   logic [31:0] wdat = '0;
   logic        rdat_valid;
   logic        rdat_ready = 1'b0;
   logic [31:0] rdat;
   logic        hecho;
   logic        ram_we;
   logic [31:0] ram_din;
   logic [3:0]  ram_dir;
   logic [31:0] ram_dout;
`ifdef SUMA_VERIFICACION_EN
   logic [31:0] suma;
`endif

   logic [31:0] mem [16];
   logic [31:0] esp [16];
   int          n_vec = 0;
   int          n_err = 0;

   typedef struct {
      logic        esc;
      logic [3:0]  dir;
      logic [4:0]  len;
      logic [31:0] base;
      logic [31:0] paso;
   } vec_t;

   vec_t tabla [8];

   controlador_rafaga_ram #(
      .ANCHO_DATOS (32),
      .ANCHO_DIR   (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_escritura (req_escritura),
      .req_dir       (req_dir),
      .req_longitud  (req_longitud),
      .wdat_valid    (wdat_valid),
      .wdat_ready    (wdat_ready),
      .wdat          (wdat),
      .rdat_valid    (rdat_valid),
      .rdat_ready    (rdat_ready),
      .rdat          (rdat),
      .hecho         (hecho),
      .ram_we        (ram_we),
      .ram_din       (ram_din),
      .ram_dir       (ram_dir),
      .ram_dout      (ram_dout)
`ifdef SUMA_VERIFICACION_EN
      ,
      .suma          (suma)
`endif
   );

   always #5 clk = ~clk;

   assign ram_dout = mem[ram_dir];
   always @(posedge clk) begin
      if (ram_we) mem[ram_dir] <= ram_din;
   end

   task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nombre, got, exp);
      end
   endtask

   task automatic ejecutar(input vec_t v);
      int         n;
      int         k;
      int         j;
      int         nwe;
      int         lat;
      logic [3:0] a;
`ifdef SUMA_VERIFICACION_EN
      logic [31:0] x;
      x = '0;
`endif
      n = (v.len > 5'd16) ? 16 : int'(v.len);
      k = 0; j = 0; nwe = 0; lat = 0;
      @(negedge clk);
      req_valid     = 1'b1;
      req_escritura = v.esc;
      req_dir       = v.dir;
      req_longitud  = v.len;
      rdat_ready    = 1'b1;
      #1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      for (int c = 1; c <= 60 && lat == 0; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (ram_we) begin
            a = v.dir + 4'(nwe);
            chk("we_dir", 32'(ram_dir), 32'(a));
            chk("we_din", ram_din, v.base + 32'(nwe) * v.paso);
            nwe++;
         end
         if (rdat_valid) begin
            a = v.dir + 4'(j);
            chk("rdat", rdat, esp[a]);
`ifdef SUMA_VERIFICACION_EN
            x = x ^ esp[a];
`endif
            j++;
         end
         if (hecho) begin
            lat = c;
`ifdef SUMA_VERIFICACION_EN
            chk("suma", suma, x);
`endif
         end
         wdat_valid = v.esc && (k < n);
         wdat       = v.base + 32'(k) * v.paso;
         #1;
         if (wdat_valid && wdat_ready) begin
`ifdef SUMA_VERIFICACION_EN
            x = x ^ wdat;
`endif
            k++;
         end
      end
      wdat_valid = 1'b0;
      chk("n_escrituras", 32'(nwe), v.esc ? 32'(n) : 32'd0);
      chk("n_lecturas", 32'(j), v.esc ? 32'd0 : 32'(n));
      chk("latencia_hecho", 32'(lat), v.esc ? 32'(2 * n + 1) : 32'(n + 1));
      @(negedge clk);
      chk("hecho_un_ciclo", 32'(hecho), 32'd0);
      chk("rdat_valid_fin", 32'(rdat_valid), 32'd0);
      chk("req_ready_fin", 32'(req_ready), 32'd1);
      if (v.esc) begin
         for (int i = 0; i < n; i++) begin
            a = v.dir + 4'(i);
            esp[a] = v.base + 32'(i) * v.paso;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tabla[0] = '{1'b1, 4'd3,  5'd4,  32'h0000_00A0, 32'd1};
      tabla[1] = '{1'b0, 4'd3,  5'd4,  32'h0,         32'd0};
      tabla[2] = '{1'b1, 4'd14, 5'd3,  32'h0000_0011, 32'h11};
      tabla[3] = '{1'b0, 4'd14, 5'd3,  32'h0,         32'd0};
      tabla[4] = '{1'b1, 4'd0,  5'd0,  32'h0000_00FF, 32'd1};
      tabla[5] = '{1'b1, 4'd5,  5'd20, 32'h0000_0100, 32'd1};
      tabla[6] = '{0,    4'd5,  5'd16, 32'h0,         32'd0};
      tabla[7] = '{1'b0, 4'd2,  5'd0,  32'h0,         32'd0};

      // Reset state, including a write word offered while idle.
      wdat_valid = 1'b1;
      wdat       = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wdat_ready", 32'(wdat_ready), 32'd0);
      chk("rst_rdat_valid", 32'(rdat_valid), 32'd0);
      chk("rst_hecho", 32'(hecho), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_dir", 32'(ram_dir), 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      chk("rst_rdat", rdat, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_wdat_ready", 32'(wdat_ready), 32'd0);
      chk("idle_ram_we", 32'(ram_we), 32'd0);
      wdat_valid = 1'b0;

      for (int i = 0; i < 8; i++) begin
         ejecutar(tabla[i]);
      end

      // Read backpressure: first word must hold while the consumer stalls.
      @(negedge clk);
      req_valid = 1'b1; req_escritura = 1'b0; req_dir = 4'd3; req_longitud = 5'd2;
      rdat_ready = 1'b0;
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_vacio", 32'(rdat_valid), 32'd0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rdat_valid", 32'(rdat_valid), 32'd1);
         chk("bp_rdat", rdat, esp[3]);
         chk("bp_req_ready_bloq", 32'(req_ready), 32'd0);
      end
      rdat_ready = 1'b1;
      @(negedge clk);
      chk("bp_rdat2", rdat, esp[4]);
      chk("bp_rdat2_valid", 32'(rdat_valid), 32'd1);
      chk("bp_hecho", 32'(hecho), 32'd1);
      @(negedge clk);
      chk("bp_consumido", 32'(rdat_valid), 32'd0);
      chk("bp_req_ready_fin", 32'(req_ready), 32'd1);

      // Reset during the second beat of a write burst.
      @(negedge clk);
      req_valid = 1'b1; req_escritura = 1'b1; req_dir = 4'd8; req_longitud = 5'd4;
      wdat_valid = 1'b1; wdat = 32'hB0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rm_we1", 32'(ram_we), 32'd1);
      wdat = 32'hB1;
      @(negedge clk);
      @(negedge clk);
      chk("rm_we2", 32'(ram_we), 32'd1);
      chk("rm_dir2", 32'(ram_dir), 32'd9);
      rst_n = 1'b0;
      #1;
      chk("rm_we_async", 32'(ram_we), 32'd0);
      chk("rm_hecho", 32'(hecho), 32'd0);
      wdat_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rm_req_ready", 32'(req_ready), 32'd1);
      chk("rm_ram_we", 32'(ram_we), 32'd0);
      chk("rm_hecho_post", 32'(hecho), 32'd0);
      esp[8] = 32'hB0;
      ejecutar('{1'b0, 4'd8, 5'd2, 32'h0, 32'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
